// File: rtl/phase_packet_parser.sv
// Host-stream decoder for phase-update packets: fills a shadow phase bank and
// copies it to the active bank coherently at a drive-period boundary.
module phase_packet_parser #(
    parameter int NUM_CHANNELS   = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                      sys_clk,
    input  logic                      ext_rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    input  logic                      period_start,
    output logic [NUM_CHANNELS*8-1:0] phases,
    output logic                      commit_pending,
    output logic                      read_error,
    output logic [15:0]               pkt_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] IDLE      = 3'd0,
                           SET_CHAN  = 3'd1,
                           SET_PHASE = 3'd2,
                           BU_START  = 3'd3,
                           BU_COUNT  = 3'd4,
                           BU_DATA   = 3'd5;

    localparam logic [7:0] CMD_SET    = 8'h01,
                           CMD_BURST  = 8'h02,
                           CMD_COMMIT = 8'h03;

    localparam logic [8:0]    NUM_CH9      = 9'(NUM_CHANNELS);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]                state;
    logic [2:0]                state_next;
    logic [7:0]                chan_reg;
    logic [8:0]                burst_idx;
    logic [7:0]                burst_left;
    logic [TW-1:0]             idle_cnt;
    logic [NUM_CHANNELS*8-1:0] shadow;

    logic       xfer;
    logic       commit_stall;
    logic       timeout_hit;
    logic       wr_en;
    logic [8:0] wr_idx;
    logic       err_set;
    logic       pkt_inc;
    logic       commit_set;

    // A second COMMIT is held off until the pending one has been applied.
    assign commit_stall = (state == IDLE) && rx_valid && (rx_data == CMD_COMMIT) && commit_pending;
    assign rx_ready     = !ext_rst && !commit_stall;
    assign xfer         = rx_valid && rx_ready;
    assign timeout_hit  = (state != IDLE) && !xfer && (idle_cnt == TIMEOUT_LAST);

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_idx     = 9'd0;
        err_set    = 1'b0;
        pkt_inc    = 1'b0;
        commit_set = 1'b0;
        if (timeout_hit) begin
            state_next = IDLE;
            err_set    = 1'b1;
        end else if (xfer) begin
            case (state)
                IDLE: begin
                    case (rx_data)
                        CMD_SET:   state_next = SET_CHAN;
                        CMD_BURST: state_next = BU_START;
                        CMD_COMMIT: begin
                            commit_set = 1'b1;
                            pkt_inc    = 1'b1;
                        end
                        default:   err_set = 1'b1;
                    endcase
                end
                SET_CHAN:  state_next = SET_PHASE;
                SET_PHASE: begin
                    wr_idx = {1'b0, chan_reg};
                    if (wr_idx < NUM_CH9) begin
                        wr_en   = 1'b1;
                        pkt_inc = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                    state_next = IDLE;
                end
                BU_START:  state_next = BU_COUNT;
                BU_COUNT: begin
                    if (rx_data == 8'd0) begin
                        state_next = IDLE;
                        pkt_inc    = 1'b1;
                    end else begin
                        state_next = BU_DATA;
                    end
                end
                BU_DATA: begin
                    // Out-of-range burst bytes are dropped but the packet still counts.
                    wr_idx = burst_idx;
                    if (wr_idx < NUM_CH9) begin
                        wr_en = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                    if (burst_left == 8'd1) begin
                        state_next = IDLE;
                        pkt_inc    = 1'b1;
                    end
                end
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (ext_rst) begin
            state          <= IDLE;
            chan_reg       <= 8'd0;
            burst_idx      <= 9'd0;
            burst_left     <= 8'd0;
            idle_cnt       <= '0;
            shadow         <= '0;
            phases         <= '0;
            commit_pending <= 1'b0;
            read_error     <= 1'b0;
            pkt_count      <= 16'd0;
        end else begin
            state <= state_next;

            if (state == IDLE || xfer || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (xfer && state == SET_CHAN) begin
                chan_reg <= rx_data;
            end

            if (xfer && state == BU_START) begin
                burst_idx <= {1'b0, rx_data};
            end else if (xfer && state == BU_DATA) begin
                burst_idx <= burst_idx + 9'd1;
            end

            if (xfer && state == BU_COUNT) begin
                burst_left <= rx_data;
            end else if (xfer && state == BU_DATA) begin
                burst_left <= burst_left - 8'd1;
            end

            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (wr_en && wr_idx == 9'(i)) begin
                    shadow[8*i +: 8] <= rx_data;
                end
            end

            // The copy takes the pre-write shadow, so a same-edge write waits for the next commit.
            if (period_start && commit_pending) begin
                phases         <= shadow;
                commit_pending <= 1'b0;
            end else if (commit_set) begin
                commit_pending <= 1'b1;
            end

            if (err_set) begin
                read_error <= 1'b1;
            end

            if (pkt_inc) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_phase_packet_parser.sv
// Directed bench for phase_packet_parser: packet decoding, coherent commit,
// commit stalling, timeout recovery and mid-packet reset.
module tb_phase_packet_parser;

    localparam int NUM_CHANNELS   = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                      sys_clk = 1'b0;
    logic                      ext_rst;
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      period_start;
    logic [NUM_CHANNELS*8-1:0] phases;
    logic                      commit_pending;
    logic                      read_error;
    logic [15:0]               pkt_count;

    int checks = 0;
    int errors = 0;

    phase_packet_parser #(
        .NUM_CHANNELS   (NUM_CHANNELS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .sys_clk        (sys_clk),
        .ext_rst        (ext_rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .period_start   (period_start),
        .phases         (phases),
        .commit_pending (commit_pending),
        .read_error     (read_error),
        .pkt_count      (pkt_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Presents one byte and holds it until it has been transferred (bounded wait).
    task automatic applyStimulus(input logic [7:0] b);
        int waitCycles;
        waitCycles = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        #1;
        while (!rx_ready && waitCycles < 100) begin
            tick();
            waitCycles++;
        end
        if (!rx_ready) begin
            checkOutput("rx_ready_wait_bound", 64'(rx_ready), 64'd1);
            rx_valid = 1'b0;
        end else begin
            tick();
            rx_valid = 1'b0;
        end
    endtask

    task automatic sendWithPeriod(input logic [7:0] b);
        rx_data      = b;
        rx_valid     = 1'b1;
        period_start = 1'b1;
        tick();
        rx_valid     = 1'b0;
        period_start = 1'b0;
    endtask

    task automatic pulsePeriod();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    task automatic doReset();
        ext_rst      = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        period_start = 1'b0;
        tick();
        tick();
        ext_rst      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        // Reset state
        ext_rst      = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        period_start = 1'b0;
        tick();
        tick();
        checkOutput("reset_rx_ready",       64'(rx_ready),       64'd0);
        checkOutput("reset_phases",         64'(phases),         64'd0);
        checkOutput("reset_commit_pending", 64'(commit_pending), 64'd0);
        checkOutput("reset_read_error",     64'(read_error),     64'd0);
        checkOutput("reset_pkt_count",      64'(pkt_count),      64'd0);
        ext_rst = 1'b0;
        tick();

        // SET ch2 = 5A, then COMMIT and a period boundary
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h5A);
        checkOutput("set_pkt_count", 64'(pkt_count), 64'd1);
        applyStimulus(8'h03);
        checkOutput("set_commit_pending",    64'(commit_pending), 64'd1);
        checkOutput("set_phases_before_pst", 64'(phases),         64'd0);
        pulsePeriod();
        checkOutput("set_phases_after",     64'(phases),         64'h005A_0000);
        checkOutput("set_commit_cleared",   64'(commit_pending), 64'd0);
        checkOutput("set_read_error",       64'(read_error),     64'd0);
        checkOutput("set_pkt_count_commit", 64'(pkt_count),      64'd2);

        // BURST of four, no commit yet, then commit
        doReset();
        applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'h04);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
        checkOutput("burst_pkt_count", 64'(pkt_count), 64'd1);
        pulsePeriod();
        checkOutput("burst_no_commit_phases", 64'(phases), 64'd0);
        applyStimulus(8'h03);
        pulsePeriod();
        checkOutput("burst_phases",    64'(phases),    64'h4433_2211);
        checkOutput("burst_pkt_after", 64'(pkt_count), 64'd2);

        // BURST overrunning the channel range: first byte lands, second dropped
        applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h02);
        applyStimulus(8'hAA); applyStimulus(8'hBB);
        checkOutput("overrun_read_error", 64'(read_error), 64'd1);
        checkOutput("overrun_pkt_count",  64'(pkt_count),  64'd3);
        applyStimulus(8'h03);
        pulsePeriod();
        checkOutput("overrun_phases", 64'(phases), 64'hAA33_2211);

        // SET to a nonexistent channel
        doReset();
        applyStimulus(8'h01); applyStimulus(8'h07); applyStimulus(8'h10);
        checkOutput("badchan_read_error", 64'(read_error), 64'd1);
        checkOutput("badchan_pkt_count",  64'(pkt_count),  64'd0);

        // Unknown command byte, parser must remain in IDLE
        doReset();
        applyStimulus(8'h7F);
        checkOutput("unknown_read_error", 64'(read_error), 64'd1);
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h99);
        checkOutput("unknown_next_pkt", 64'(pkt_count), 64'd1);
        applyStimulus(8'h03);
        pulsePeriod();
        checkOutput("unknown_next_phases", 64'(phases), 64'h0000_0099);

        // Second COMMIT stalls until the first is applied
        doReset();
        applyStimulus(8'h01); applyStimulus(8'h01); applyStimulus(8'h77);
        applyStimulus(8'h03);
        rx_data  = 8'h03;
        rx_valid = 1'b1;
        #1;
        checkOutput("stall_ready_low", 64'(rx_ready), 64'd0);
        tick();
        tick();
        checkOutput("stall_ready_still_low", 64'(rx_ready),       64'd0);
        checkOutput("stall_pending",         64'(commit_pending), 64'd1);
        checkOutput("stall_pkt_count",       64'(pkt_count),      64'd2);
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        checkOutput("stall_applied_pending", 64'(commit_pending), 64'd0);
        checkOutput("stall_ready_high",      64'(rx_ready),       64'd1);
        checkOutput("stall_applied_phases",  64'(phases),         64'h0000_7700);
        tick();
        rx_valid = 1'b0;
        checkOutput("stall_second_pending", 64'(commit_pending), 64'd1);
        checkOutput("stall_second_pkt",     64'(pkt_count),      64'd3);

        // Same-edge interactions between commit, period_start and shadow writes
        doReset();
        applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h12);
        sendWithPeriod(8'h03);
        checkOutput("sameedge_commit_pending", 64'(commit_pending), 64'd1);
        checkOutput("sameedge_commit_phases",  64'(phases),         64'd0);
        applyStimulus(8'h01); applyStimulus(8'h00);
        sendWithPeriod(8'h34);
        checkOutput("sameedge_write_phases",  64'(phases),         64'h0000_0012);
        checkOutput("sameedge_write_pending", 64'(commit_pending), 64'd0);
        applyStimulus(8'h03);
        pulsePeriod();
        checkOutput("sameedge_write_landed", 64'(phases),    64'h0000_0034);
        checkOutput("sameedge_pkt_count",    64'(pkt_count), 64'd4);

        // Inter-byte timeout inside a SET
        doReset();
        applyStimulus(8'h01); applyStimulus(8'h01);
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
        checkOutput("timeout_not_yet", 64'(read_error), 64'd0);
        tick();
        checkOutput("timeout_read_error", 64'(read_error), 64'd1);
        applyStimulus(8'h01); applyStimulus(8'h01); applyStimulus(8'h33);
        checkOutput("timeout_recover_pkt", 64'(pkt_count), 64'd1);
        applyStimulus(8'h03);
        pulsePeriod();
        checkOutput("timeout_recover_phases", 64'(phases),    64'h0000_3300);
        checkOutput("timeout_recover_pkt2",   64'(pkt_count), 64'd2);

        // Reset in the middle of a burst
        applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'h04);
        applyStimulus(8'h55); applyStimulus(8'h66);
        ext_rst = 1'b1;
        #1;
        checkOutput("midrst_rx_ready", 64'(rx_ready), 64'd0);
        tick();
        checkOutput("midrst_phases",     64'(phases),         64'd0);
        checkOutput("midrst_pkt_count",  64'(pkt_count),      64'd0);
        checkOutput("midrst_read_error", 64'(read_error),     64'd0);
        checkOutput("midrst_pending",    64'(commit_pending), 64'd0);
        ext_rst = 1'b0;
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'hC3);
        checkOutput("midrst_leftover_pkt", 64'(pkt_count), 64'd1);
        applyStimulus(8'h03);
        pulsePeriod();
        checkOutput("midrst_leftover_phases", 64'(phases),     64'h00C3_0000);
        checkOutput("midrst_leftover_error",  64'(read_error), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
